// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All-ones anode pattern for a display of the given digit count (1..8)
    function automatic logic [7:0] an_off(input int width);
        return 8'((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low segments
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment driver with frame-aligned double buffering
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lz_suppress_i,
    input  logic                    load_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [7:0] AN_ALL = an_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ALL[NUM_DIGITS-1:0];

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    slot_end;
    logic                    frame_wrap;

    logic [4*NUM_DIGITS-1:0] stg_digits, disp_digits;
    logic [NUM_DIGITS-1:0]   stg_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   stg_blank, disp_blank;
    logic                    stg_lz, disp_lz;
    logic                    pending;

    logic [NUM_DIGITS-1:0]   suppress;
    logic                    dark;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_next;

    assign slot_end   = (presc == P_LAST);
    assign frame_wrap = slot_end && (idx == I_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load on the wrap cycle lands in staging only; display takes the older staging copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_digits  <= '0;
            stg_dp      <= '0;
            stg_blank   <= '0;
            stg_lz      <= 1'b0;
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_blank  <= '0;
            disp_lz     <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (frame_wrap && pending) begin
                disp_digits <= stg_digits;
                disp_dp     <= stg_dp;
                disp_blank  <= stg_blank;
                disp_lz     <= stg_lz;
            end
            if (load_i) begin
                stg_digits <= digits_i;
                stg_dp     <= dp_i;
                stg_blank  <= blank_i;
                stg_lz     <= lz_suppress_i;
            end
            pending <= load_i | (pending & ~frame_wrap);
        end
    end

    // Walk from the most significant digit down while every nibble so far is zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        suppress = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run & (disp_digits[4*k +: 4] == 4'h0);
            suppress[k] = disp_lz & zero_run & (k != 0);
        end
    end

    assign dark = disp_blank[idx] | suppress[idx];

    seg7_hex_decode u_decode (
        .nibble (disp_digits[4*idx +: 4]),
        .seg    (dec_seg)
    );

    // First cycle of each slot keeps every anode off while segments settle
    always_comb begin
        an_next = AN_OFF;
        if ((presc != '0) && !dark) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o    <= AN_OFF;
            seg_o   <= SEG_OFF;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_next;
            seg_o   <= dark ? SEG_OFF : dec_seg;
            dp_o    <= dark | ~disp_dp[idx];
            frame_o <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots)
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic        lz_suppress_i;
    logic        load_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digits_i      (digits_i),
        .dp_i          (dp_i),
        .blank_i       (blank_i),
        .lz_suppress_i (lz_suppress_i),
        .load_i        (load_i),
        .an_o          (an_o),
        .seg_o         (seg_o),
        .dp_o          (dp_o),
        .frame_o       (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // segs = {slot3, slot2, slot1, slot0}; dpo = expected dp_o per slot; dark = slots with anode held off
    typedef struct {
        int          frame_no;
        logic [27:0] segs;
        logic [3:0]  dpo;
        logic [3:0]  dark;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   fcount = 0;
    int   pos    = 0;
    bit   in_frame = 0;
    bit   active   = 0;

    task automatic check_sample(input int p);
        int         j;
        int         k;
        logic [3:0] one;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        logic       ef;
        j   = p / 4;
        k   = p % 4;
        one = 4'b0001;
        ea  = (k == 0 || cur.dark[j]) ? 4'hF : ~(one << j);
        es  = cur.segs[7*j +: 7];
        ed  = cur.dpo[j];
        ef  = (p == 15);
        checks++;
        if (an_o !== ea || seg_o !== es || dp_o !== ed || frame_o !== ef) begin
            errors++;
            $display("FAIL scan frame%0d pos%0d got an=%b seg=%h dp=%b frame=%b required an=%b seg=%h dp=%b frame=%b",
                     cur.frame_no, p, an_o, seg_o, dp_o, frame_o, ea, es, ed, ef);
        end
    endtask

    // Monitor: frame_o opens a 16-sample window that is compared against the queued image
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                active   = 0;
            end else begin
                if (in_frame) begin
                    if (active) check_sample(pos);
                    pos++;
                    if (pos == 16) in_frame = 0;
                end
                if (frame_o) begin
                    fcount++;
                    in_frame = 1;
                    pos      = 0;
                    active   = 0;
                    while (q.size() > 0 && q[0].frame_no < fcount) begin
                        checks++;
                        errors++;
                        $display("FAIL missed_frame expected frame %0d, got frame %0d first", q[0].frame_no, fcount);
                        void'(q.pop_front());
                    end
                    if (q.size() > 0 && q[0].frame_no == fcount) begin
                        cur    = q.pop_front();
                        active = 1;
                    end
                end
            end
        end
    end

    task automatic check_eq(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic wait_frame();
        int  start;
        bit  seen;
        start = fcount;
        seen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (fcount != start) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_timeout got no frame_o in 40 cycles required a pulse");
        end
    endtask

    task automatic push(input int f, input logic [27:0] segs, input logic [3:0] dpo, input logic [3:0] dark);
        exp_t e;
        e.frame_no = f;
        e.segs     = segs;
        e.dpo      = dpo;
        e.dark     = dark;
        q.push_back(e);
    endtask

    // One-cycle load strobe, then scramble the inputs to prove they are ignored without load_i
    task automatic load_vec(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
        digits_i      = d;
        dp_i          = dp;
        blank_i       = bl;
        lz_suppress_i = lz;
        load_i        = 1'b1;
        @(negedge clk);
        #1;
        load_i        = 1'b0;
        digits_i      = ~d;
        dp_i          = ~dp;
        blank_i       = ~bl;
        lz_suppress_i = ~lz;
    endtask

    task automatic step(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic lz,
                        input logic [27:0] segs, input logic [3:0] dpo, input logic [3:0] dark);
        int f;
        f = fcount;
        repeat (5) @(negedge clk);
        #1;
        push(f + 1, segs, dpo, dark);
        push(f + 2, segs, dpo, dark);
        load_vec(d, dp, bl, lz);
        wait_frame();
        wait_frame();
    endtask

    localparam logic [27:0] ALL_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};

    initial begin
        int f;
        int cnt;
        rst_n = 1'b0; digits_i = '0; dp_i = '0; blank_i = '0; lz_suppress_i = 1'b0; load_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_an", {4'h0, an_o}, 8'h0F);
        check_eq("reset_seg", {1'b0, seg_o}, 8'h7F);
        check_eq("reset_dp", {7'h0, dp_o}, 8'h01);
        check_eq("reset_frame", {7'h0, frame_o}, 8'h00);

        push(1, ALL_ZERO, 4'b1111, 4'b0000);
        push(2, ALL_ZERO, 4'b1111, 4'b0000);
        rst_n = 1'b1;
        wait_frame();
        wait_frame();

        step(16'h1234, 4'b0100, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011, 4'b0000);
        step(16'h0050, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, 4'b1100);
        step(16'h0000, 4'b1111, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110, 4'b1110);
        step(16'h0105, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111, 4'b1000);

        // Two loads in one frame: only the last one shows, and not before the boundary
        f = fcount;
        repeat (3) @(negedge clk);
        #1;
        push(f + 1, {7'h03, 7'h03, 7'h03, 7'h03}, 4'b1111, 4'b0000);
        push(f + 2, {7'h03, 7'h03, 7'h03, 7'h03}, 4'b1111, 4'b0000);
        load_vec(16'hAAAA, 4'b0000, 4'b0000, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        load_vec(16'hBBBB, 4'b0000, 4'b0000, 1'b0);
        wait_frame();
        wait_frame();

        step(16'h1234, 4'b1111, 4'b1001, 1'b0, {7'h7F, 7'h24, 7'h30, 7'h7F}, 4'b1001, 4'b1001);

        // X loaded mid-frame, Y strobed exactly on the following boundary edge
        f = fcount;
        push(f + 1, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1111, 4'b0000);
        push(f + 2, {7'h02, 7'h78, 7'h00, 7'h10}, 4'b1111, 4'b0000);
        load_vec(16'hCDEF, 4'b0000, 4'b0000, 1'b0);
        repeat (14) @(negedge clk);
        #1;
        load_vec(16'h6789, 4'b0000, 4'b0000, 1'b0);
        wait_frame();
        wait_frame();

        // Asynchronous reset in the middle of a lit slot
        repeat (6) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_an", {4'h0, an_o}, 8'h0F);
        check_eq("async_rst_seg", {1'b0, seg_o}, 8'h7F);
        check_eq("async_rst_dp", {7'h0, dp_o}, 8'h01);
        check_eq("async_rst_frame", {7'h0, frame_o}, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        push(fcount + 1, ALL_ZERO, 4'b1111, 4'b0000);
        push(fcount + 2, ALL_ZERO, 4'b1111, 4'b0000);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 40 && cnt == 0; i++) begin
            @(negedge clk);
            #1;
            if (frame_o) cnt = i;
        end
        check_eq("first_frame_after_reset", 8'(cnt), 8'd16);
        wait_frame();
        wait_frame();
        check_eq("queue_drained", 8'(q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion by 100000 required summary");
        $fatal(1, "watchdog");
    end

endmodule
